// File: rtl/regbank_access_arbiter.sv
// Round-robin access controller for a bank of falling-edge register flops.
// Grants one read or write per two cycles and runs a walking sequential clear.
module regbank_access_arbiter #(
  parameter int DATA_W = 8,
  parameter int NREG   = 4,
  parameter int ADDR_W = 2
) (
  input  logic                     clk,
  input  logic                     sync_reset_n,
  input  logic                     req0,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        addr0,
  input  logic [DATA_W-1:0]        wdata0,
  input  logic                     req1,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        addr1,
  input  logic [DATA_W-1:0]        wdata1,
  output logic                     gnt0,
  output logic                     gnt1,
  output logic                     rvalid0,
  output logic                     rvalid1,
  output logic [DATA_W-1:0]        rdata,
  input  logic                     clr_req,
  output logic                     clr_busy,
  output logic [NREG-1:0]          bank_load,
  output logic [DATA_W-1:0]        bank_d,
  output logic                     bank_clr,
  input  logic [NREG*DATA_W-1:0]   bank_q
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    CLEAR = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREG - 1);

  state_t            state;
  logic              last_gnt1;
  logic [ADDR_W-1:0] clr_idx;

  logic              pick1;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [DATA_W-1:0] q_arr [NREG];

  function automatic logic [NREG-1:0] onehot(input logic [ADDR_W-1:0] idx);
    onehot = NREG'(1) << idx;
  endfunction

  for (genvar i = 0; i < NREG; i++) begin : g_unpack
    assign q_arr[i] = bank_q[i*DATA_W +: DATA_W];
  end

  // The bank clears at the falling edge inside any reset cycle.
  assign bank_clr = ~sync_reset_n;

  // Contention goes to whoever did not win last; a lone request simply wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    pick1 = 1'b0;
    if (req0 && req1) begin
      pick1 = ~last_gnt1;
    end else begin
      pick1 = req1;
    end
    sel_we    = pick1 ? we1    : we0;
    sel_addr  = pick1 ? addr1  : addr0;
    sel_wdata = pick1 ? wdata1 : wdata0;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values regardless of statement order.
    if (!sync_reset_n) begin
      state     <= IDLE;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      rdata     <= '0;
      clr_busy  <= 1'b0;
      bank_load <= '0;
      bank_d    <= '0;
      last_gnt1 <= 1'b1;
      clr_idx   <= '0;
    end else begin
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      bank_load <= '0;
      clr_busy  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (clr_req) begin
            // Entry already loads register 0, giving exactly NREG busy cycles.
            state     <= CLEAR;
            clr_busy  <= 1'b1;
            bank_load <= onehot('0);
            bank_d    <= '0;
            clr_idx   <= ADDR_W'(1);
          end else if (req0 || req1) begin
            state     <= SERVE;
            last_gnt1 <= pick1;
            gnt0      <= ~pick1;
            gnt1      <= pick1;
            if (sel_we) begin
              bank_load <= onehot(sel_addr);
              bank_d    <= sel_wdata;
            end else begin
              rdata   <= q_arr[sel_addr];
              rvalid0 <= ~pick1;
              rvalid1 <= pick1;
            end
          end
        end
        SERVE: begin
          state <= IDLE;
        end
        CLEAR: begin
          clr_busy  <= 1'b1;
          bank_load <= onehot(clr_idx);
          bank_d    <= '0;
          if (clr_idx == LAST_IDX) begin
            state   <= IDLE;
            clr_idx <= '0;
          end else begin
            clr_idx <= clr_idx + ADDR_W'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  a_gnt_excl : assert property (@(posedge clk) disable iff (!sync_reset_n)
    !(gnt0 && gnt1));
  a_load_onehot : assert property (@(posedge clk) disable iff (!sync_reset_n)
    $onehot0(bank_load));

endmodule

// File: tb/tb_regbank_access_arbiter.sv
// Randomized and directed bench for regbank_access_arbiter, compared cycle by
// cycle against a transaction-level model and a behavioural falling-edge bank.
module tb_regbank_access_arbiter;

  localparam int DATA_W = 8;
  localparam int NREG   = 4;
  localparam int ADDR_W = 2;

  logic                   clk = 1'b0;
  logic                   sync_reset_n;
  logic                   req0, we0, req1, we1;
  logic [ADDR_W-1:0]      addr0, addr1;
  logic [DATA_W-1:0]      wdata0, wdata1;
  logic                   gnt0, gnt1, rvalid0, rvalid1;
  logic [DATA_W-1:0]      rdata;
  logic                   clr_req, clr_busy;
  logic [NREG-1:0]        bank_load;
  logic [DATA_W-1:0]      bank_d;
  logic                   bank_clr;
  logic [NREG*DATA_W-1:0] bank_q;

  int n_cmp = 0;
  int n_bad = 0;
  bit hold_en = 1'b0;

  always #5 clk = ~clk;

  regbank_access_arbiter #(.DATA_W(DATA_W), .NREG(NREG), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .sync_reset_n(sync_reset_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .clr_req(clr_req), .clr_busy(clr_busy),
    .bank_load(bank_load), .bank_d(bank_d), .bank_clr(bank_clr),
    .bank_q(bank_q)
  );

  // Falling-edge register bank with active-high synchronous clear.
  logic [DATA_W-1:0] bank [NREG];
  always @(negedge clk) begin
    for (int i = 0; i < NREG; i++) begin
      if (bank_clr)          bank[i] <= '0;
      else if (bank_load[i]) bank[i] <= bank_d;
    end
  end
  always_comb begin
    bank_q = '0;
    for (int i = 0; i < NREG; i++) bank_q[i*DATA_W +: DATA_W] = bank[i];
  end

  // Reference model: what each rising edge should produce, from the rules.
  logic [DATA_W-1:0] ref_mem [NREG];
  int                clr_left = 0;
  bit                serving  = 1'b0;
  int                last_win = 1;
  bit                e_gnt0, e_gnt1, e_rv0, e_rv1, e_busy;
  bit                chk_rdata, chk_d;
  logic [DATA_W-1:0] e_rdata, e_d;
  logic [NREG-1:0]   e_load;

  always @(posedge clk) begin
    int w, k;
    logic [ADDR_W-1:0] a;
    e_gnt0 = 0; e_gnt1 = 0; e_rv0 = 0; e_rv1 = 0; e_busy = 0;
    e_load = '0; chk_rdata = 0; chk_d = 0;
    if (!sync_reset_n) begin
      e_rdata = '0; e_d = '0; chk_rdata = 1; chk_d = 1;
      last_win = 1; clr_left = 0; serving = 0;
      for (int i = 0; i < NREG; i++) ref_mem[i] = '0;
    end else if (clr_left > 0) begin
      k = NREG - clr_left;
      e_load = NREG'(1) << k; e_d = '0; chk_d = 1; e_busy = 1;
      ref_mem[k] = '0;
      clr_left--;
    end else if (serving) begin
      serving = 0;
    end else if (clr_req) begin
      e_busy = 1; e_load = NREG'(1); e_d = '0; chk_d = 1;
      ref_mem[0] = '0;
      clr_left = NREG - 1;
    end else if (req0 || req1) begin
      w = (req0 && req1) ? 1 - last_win : (req1 ? 1 : 0);
      last_win = w;
      serving  = 1;
      if (w == 0) e_gnt0 = 1; else e_gnt1 = 1;
      a = (w == 0) ? addr0 : addr1;
      if ((w == 0) ? we0 : we1) begin
        e_d = (w == 0) ? wdata0 : wdata1;
        e_load = NREG'(1) << a; chk_d = 1;
        ref_mem[a] = e_d;
      end else begin
        e_rdata = ref_mem[a]; chk_rdata = 1;
        if (w == 0) e_rv0 = 1; else e_rv1 = 1;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic compare_outputs();
    check("gnt0", gnt0, e_gnt0);
    check("gnt1", gnt1, e_gnt1);
    check("rvalid0", rvalid0, e_rv0);
    check("rvalid1", rvalid1, e_rv1);
    check("clr_busy", clr_busy, e_busy);
    check("bank_load", bank_load, e_load);
    check("bank_clr", bank_clr, !sync_reset_n);
    check("load_onehot0", $countones(bank_load) <= 1, 1);
    check("gnt_excl", gnt0 && gnt1, 0);
    if (chk_rdata) check("rdata", rdata, e_rdata);
    if (chk_d)     check("bank_d", bank_d, e_d);
  endtask

  // One cycle: check outputs on the falling edge, then update drivers just after the rising edge.
  task automatic step();
    @(negedge clk);
    compare_outputs();
    @(posedge clk);
    #1;
    if (gnt0 && !hold_en) req0 = 1'b0;
    if (gnt1 && !hold_en) req1 = 1'b0;
  endtask

  task automatic access(input int who, input bit we, input int addr, input int data);
    if (who == 0) begin
      req0 = 1; we0 = we; addr0 = ADDR_W'(addr); wdata0 = DATA_W'(data);
    end else begin
      req1 = 1; we1 = we; addr1 = ADDR_W'(addr); wdata1 = DATA_W'(data);
    end
    for (int t = 0; t < 20 && ((who == 0) ? req0 : req1); t++) step();
    check("access_timeout", (who == 0) ? req0 : req1, 0);
    step();
  endtask

  initial begin
    sync_reset_n = 0; clr_req = 0;
    req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
    @(posedge clk); #1;
    step(); step();
    sync_reset_n = 1;
    step();

    // Write then read back through the other requester.
    access(0, 1, 2, 8'hA5);
    access(1, 0, 2, 0);

    // Both requesters held from reset: grants alternate starting with 0.
    sync_reset_n = 0;
    hold_en = 1;
    req0 = 1; we0 = 0; addr0 = 2'd0;
    req1 = 1; we1 = 0; addr1 = 2'd1;
    step();
    sync_reset_n = 1;
    for (int i = 0; i < 8; i++) step();
    hold_en = 0; req0 = 0; req1 = 0;
    step(); step();

    // Fill with 0xFF, clear, and a request arriving mid-clear.
    for (int i = 0; i < NREG; i++) access(0, 1, i, 8'hFF);
    clr_req = 1;
    step();
    clr_req = 0;
    step();
    access(1, 0, 3, 0);
    for (int i = 0; i < NREG; i++) access(i % 2, 0, i, 0);

    // Clear and request rising together: clear goes first.
    access(1, 1, 1, 8'h3C);
    clr_req = 1;
    req0 = 1; we0 = 0; addr0 = 2'd1;
    step();
    clr_req = 0;
    for (int t = 0; t < 20 && req0; t++) step();
    check("clr_then_gnt0_timeout", req0, 0);
    step();

    // Reset while the clear is loading index 2.
    access(0, 1, 3, 8'h77);
    clr_req = 1;
    step();
    clr_req = 0;
    for (int t = 0; t < 10 && bank_load != 4'b0100; t++) step();
    check("clear_idx2_seen", bank_load, 4'b0100);
    sync_reset_n = 0;
    step();
    sync_reset_n = 1;
    step();
    for (int i = 0; i < NREG; i++) access(0, 0, i, 0);

    // Randomized traffic with occasional clear pulses and resets.
    for (int n = 0; n < 3000; n++) begin
      if (!req0 && $urandom_range(0, 2) == 0) begin
        req0 = 1; we0 = 1'($urandom); addr0 = ADDR_W'($urandom); wdata0 = DATA_W'($urandom);
      end
      if (!req1 && $urandom_range(0, 2) == 0) begin
        req1 = 1; we1 = 1'($urandom); addr1 = ADDR_W'($urandom); wdata1 = DATA_W'($urandom);
      end
      clr_req = ($urandom_range(0, 24) == 0);
      sync_reset_n = ($urandom_range(0, 399) != 0);
      if (!sync_reset_n) begin
        req0 = 0; req1 = 0;
      end
      step();
    end
    clr_req = 0; sync_reset_n = 1;
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
